// File: rtl/range_finder_pkg.sv
// range_finder_pkg
// Shared definitions for the multi-mode range finder: the controller state
// type and the result-mode encodings that are latched at the start of a run.
package range_finder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RANGE = 2'b00;
  localparam logic [1:0] MODE_MAX   = 2'b01;
  localparam logic [1:0] MODE_MIN   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

endpackage

// File: rtl/range_finder_multi_minmax.sv
// range_minmax
// Combinational min/max update for one sample.
// Ports:
//   load     - first sample of a run: both extremes take the sample
//   sample   - incoming unsigned sample
//   cur_min  - running minimum so far
//   cur_max  - running maximum so far
//   next_min - updated minimum
//   next_max - updated maximum
module range_minmax #(
  parameter int WIDTH = 8
) (
  input  logic             load,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  output logic [WIDTH-1:0] next_min,
  output logic [WIDTH-1:0] next_max
);

  // Seed both extremes on load, otherwise widen them to cover the sample.
  always_comb begin
    next_min = cur_min;
    next_max = cur_max;
    if (load) begin
      next_min = sample;
      next_max = sample;
    end else begin
      if (sample < cur_min) next_min = sample;
      if (sample > cur_max) next_max = sample;
    end
  end

endmodule

// File: rtl/range_finder_multi.sv
// range_finder_multi
// Streams unsigned samples between a go pulse and a finish strobe and reports
// range (max-min), max or min according to the mode latched at go, together
// with a saturating sample count.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   data_in    - sample, taken on the go cycle, every RUN cycle and finish cycle
//   go         - start a run (legal when finish=0 and mode!=11, outside RUN)
//   finish     - end a run; its sample is included
//   mode       - 00 range, 01 max, 10 min, 11 reserved (error)
//   result     - selected result while valid, else 0
//   valid      - result and count are final (DONE)
//   busy       - run in progress (RUN)
//   error      - protocol or mode error, sticky until the next legal go
//   count      - samples in the current/last run, saturating at all-ones
//   sat        - count has saturated
module range_finder_multi
  import range_finder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] min_q, max_q, min_d, max_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] count_q, count_inc;
  logic             sat_q;
  logic             legal_go;
  logic             load;
  logic             update;

  assign legal_go  = go && !finish && (mode != MODE_RSVD);
  assign count_inc = count_q + CNT_W'(1);

  range_minmax #(
    .WIDTH(WIDTH)
  ) u_minmax (
    .load    (load),
    .sample  (data_in),
    .cur_min (min_q),
    .cur_max (max_q),
    .next_min(min_d),
    .next_max(max_d)
  );

  // Next-state decode. go+finish together is an error everywhere; a legal go
  // outside RUN starts a run; finish alone is only an error from IDLE and is
  // ignored in DONE/ERR. In RUN a stray go is ignored and sampling continues.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    update  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (go && finish) begin
          state_d = ERR;
        end else begin
          update = 1'b1;
          if (finish) state_d = DONE;
        end
      end
      default: begin
        if (go && finish) begin
          state_d = ERR;
        end else if (legal_go) begin
          state_d = RUN;
          load    = 1'b1;
        end else if (go) begin
          state_d = ERR;
        end else if (finish && (state_q == IDLE)) begin
          state_d = ERR;
        end
      end
    endcase
  end

  // State, extremes, latched mode and the saturating counter. The count is
  // left untouched on error entry so the last value stays observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      mode_q  <= MODE_RANGE;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        min_q   <= min_d;
        max_q   <= max_d;
        mode_q  <= mode;
        count_q <= CNT_W'(1);
        sat_q   <= 1'b0;
      end else if (update) begin
        min_q <= min_d;
        max_q <= max_d;
        if (count_q != '1) begin
          count_q <= count_inc;
          if (count_inc == '1) sat_q <= 1'b1;
        end
      end
    end
  end

  // Result mux; only DONE exposes a non-zero result.
  always_comb begin
    result = '0;
    if (state_q == DONE) begin
      case (mode_q)
        MODE_RANGE: result = max_q - min_q;
        MODE_MAX:   result = max_q;
        MODE_MIN:   result = min_q;
        default:    result = '0;
      endcase
    end
  end

  assign valid = (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign error = (state_q == ERR);
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_range_finder_multi.sv
// tb_range_finder_multi
// Drives two range finders (CNT_W=8 and CNT_W=3) with the same stream and
// compares both against a sample-queue reference model, plus constant tables.
module tb_range_finder_multi;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       go;
  logic       finish;
  logic [1:0] mode;

  logic [7:0] r8, r3;
  logic       v8, b8, e8, s8, v3, b3, e3, s3;
  logic [7:0] c8;
  logic [2:0] c3;

  int check_count = 0;
  int fail_count  = 0;

  range_finder_multi #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .go(go), .finish(finish),
    .mode(mode), .result(r8), .valid(v8), .busy(b8), .error(e8),
    .count(c8), .sat(s8)
  );

  range_finder_multi #(.WIDTH(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .go(go), .finish(finish),
    .mode(mode), .result(r3), .valid(v3), .busy(b3), .error(e3),
    .count(c3), .sat(s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the samples of the current/last run kept in a queue,
  // and the protocol phase the specification describes.
  typedef enum int {P_IDLE, P_RUN, P_DONE, P_ERR} phase_t;
  phase_t      phase;
  int unsigned samples[$];
  int unsigned run_mode;

  task automatic modelReset();
    phase = P_IDLE;
    samples.delete();
    run_mode = 0;
  endtask

  task automatic modelStep(input logic g, input logic f, input logic [1:0] m,
                           input logic [7:0] d);
    if (g && f) begin
      phase = P_ERR;
    end else if (phase == P_RUN) begin
      samples.push_back(d);
      if (f) phase = P_DONE;
    end else if (g && m != 2'b11) begin
      samples.delete();
      samples.push_back(d);
      run_mode = m;
      phase = P_RUN;
    end else if (g) begin
      phase = P_ERR;
    end else if (f && phase == P_IDLE) begin
      phase = P_ERR;
    end
  endtask

  function automatic int unsigned modelResult();
    int unsigned mx, mn;
    if (phase != P_DONE) return 0;
    mx = 0;
    mn = 255;
    foreach (samples[i]) begin
      if (samples[i] > mx) mx = samples[i];
      if (samples[i] < mn) mn = samples[i];
    end
    case (run_mode)
      0: return mx - mn;
      1: return mx;
      2: return mn;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int unsigned act,
                       input int unsigned exp);
    check_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic f,
                               input logic [1:0] m, input logic [7:0] d);
    go = g;
    finish = f;
    mode = m;
    data_in = d;
    @(posedge clk);
    modelStep(g, f, m, d);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int unsigned n;
    int unsigned res;
    n = samples.size();
    res = modelResult();
    check({tag, " result8"}, r8, res);
    check({tag, " valid8"}, v8, phase == P_DONE);
    check({tag, " busy8"}, b8, phase == P_RUN);
    check({tag, " error8"}, e8, phase == P_ERR);
    check({tag, " count8"}, c8, (n > 255) ? 255 : n);
    check({tag, " sat8"}, s8, n >= 255);
    check({tag, " result3"}, r3, res);
    check({tag, " valid3"}, v3, phase == P_DONE);
    check({tag, " busy3"}, b3, phase == P_RUN);
    check({tag, " error3"}, e3, phase == P_ERR);
    check({tag, " count3"}, c3, (n > 7) ? 7 : n);
    check({tag, " sat3"}, s3, n >= 7);
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    go = 1'b0;
    finish = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       go;
    logic       finish;
    logic [1:0] mode;
    logic [7:0] data;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_error;
    logic [7:0] exp_result;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    finish = 1'b0;
    mode = 2'b00;
    data_in = 8'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkOutput("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Range run from the test plan, then DONE holding through idle/finish.
    vecs.push_back('{1'b1, 1'b0, 2'd0, 8'd40,  1'b0, 1'b1, 1'b0, 8'd0,   8'd1});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 8'd10,  1'b0, 1'b1, 1'b0, 8'd0,   8'd2});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 8'd200, 1'b0, 1'b1, 1'b0, 8'd0,   8'd3});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 8'd90,  1'b0, 1'b1, 1'b0, 8'd0,   8'd4});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 8'd70,  1'b1, 1'b0, 1'b0, 8'd190, 8'd5});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd190, 8'd5});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 8'd3,   1'b1, 1'b0, 1'b0, 8'd190, 8'd5});
    // Back-to-back max run with a mode change mid-run (ignored).
    vecs.push_back('{1'b1, 1'b0, 2'd1, 8'd40,  1'b0, 1'b1, 1'b0, 8'd0,   8'd1});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 8'd10,  1'b0, 1'b1, 1'b0, 8'd0,   8'd2});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 8'd200, 1'b0, 1'b1, 1'b0, 8'd0,   8'd3});
    vecs.push_back('{1'b0, 1'b0, 2'd3, 8'd90,  1'b0, 1'b1, 1'b0, 8'd0,   8'd4});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 8'd70,  1'b1, 1'b0, 1'b0, 8'd200, 8'd5});
    // Min run on the same stream.
    vecs.push_back('{1'b1, 1'b0, 2'd2, 8'd40,  1'b0, 1'b1, 1'b0, 8'd0,   8'd1});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 8'd10,  1'b0, 1'b1, 1'b0, 8'd0,   8'd2});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 8'd200, 1'b0, 1'b1, 1'b0, 8'd0,   8'd3});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 8'd90,  1'b0, 1'b1, 1'b0, 8'd0,   8'd4});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 8'd70,  1'b1, 1'b0, 1'b0, 8'd10,  8'd5});
    // Single-sample run with equal samples: count 2, range 0.
    vecs.push_back('{1'b1, 1'b0, 2'd0, 8'd50,  1'b0, 1'b1, 1'b0, 8'd0,   8'd1});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 8'd50,  1'b1, 1'b0, 1'b0, 8'd0,   8'd2});
    // go and finish together from DONE: error, count kept.
    vecs.push_back('{1'b1, 1'b1, 2'd0, 8'd9,   1'b0, 1'b0, 1'b1, 8'd0,   8'd2});
    // go with reserved mode while in ERR keeps the error.
    vecs.push_back('{1'b1, 1'b0, 2'd3, 8'd9,   1'b0, 1'b0, 1'b1, 8'd0,   8'd2});
    // Legal go clears the error.
    vecs.push_back('{1'b1, 1'b0, 2'd0, 8'd7,   1'b0, 1'b1, 1'b0, 8'd0,   8'd1});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 8'd3,   1'b1, 1'b0, 1'b0, 8'd4,   8'd2});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].go, vecs[i].finish, vecs[i].mode, vecs[i].data);
      check($sformatf("tbl%0d valid", i), v8, vecs[i].exp_valid);
      check($sformatf("tbl%0d busy", i), b8, vecs[i].exp_busy);
      check($sformatf("tbl%0d error", i), e8, vecs[i].exp_error);
      check($sformatf("tbl%0d result", i), r8, vecs[i].exp_result);
      check($sformatf("tbl%0d count", i), c8, vecs[i].exp_count);
      checkOutput($sformatf("tbl%0d model", i));
    end

    // Reset mid-run: outputs clear without waiting for a clock edge.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd5);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd9);
    go = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    check("async_rst busy", b8, 0);
    check("async_rst count", c8, 0);
    checkOutput("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    check("post_rst valid", v8, 0);
    checkOutput("post_rst");

    // finish alone in IDLE after reset is an error.
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd1);
    check("fin_idle error", e8, 1);
    checkOutput("fin_idle");
    doReset();

    // Reserved mode at go from IDLE is an error; a legal go clears it.
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd1);
    check("rsvd error", e8, 1);
    checkOutput("rsvd");
    applyStimulus(1'b1, 1'b0, 2'd1, 8'd1);
    check("rsvd_clear error", e8, 0);
    checkOutput("rsvd_clear");
    applyStimulus(1'b0, 1'b1, 2'd1, 8'd2);
    checkOutput("rsvd_done");

    // Saturation: ten samples 1..10 saturate the 3-bit counter.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd1);
    for (int k = 2; k <= 9; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 8'(k));
      checkOutput("sat_run");
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd10);
    check("sat count3", c3, 7);
    check("sat flag3", s3, 1);
    check("sat result3", r3, 9);
    check("sat count8", c8, 10);
    checkOutput("sat_done");

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic g, f;
      logic [1:0] m;
      g = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 9) == 0);
      m = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(g, f, m, 8'($urandom));
      checkOutput("rand");
      if ($urandom_range(0, 199) == 0) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/range_finder_multi.md
Name: range_finder_multi

Overview:
- Parametrised successor to the 8-bit single-mode range finder.
- Streams unsigned samples between a go pulse and a finish strobe. Reports range (max-min), max or min, selectable per run, plus a saturating sample count.
- Adds mode selection, a sample counter with saturation flag, a reserved-mode error, and explicit valid/busy status.
- Sits behind the tt_um top wrapper: data on ui_in, controls on uio_in, result on uo_out.

Parameters:
WIDTH, 8, sample and result width in bits (>=2)
CNT_W, 8, sample counter width in bits (>=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  unsigned sample, read every cycle while sampling
go  input  1  start a run; data_in on the go cycle is the first sample
finish  input  1  end a run; data_in on the finish cycle is the last sample
mode  input  2  00 range, 01 max, 10 min, 11 reserved; latched on the accepted go cycle
result  output  WIDTH  selected result, valid when valid=1, else 0
valid  output  1  result and count are final
busy  output  1  run in progress
error  output  1  protocol or mode error, sticky until next legal go
count  output  CNT_W  samples taken in the current/last run, saturating
sat  output  1  count saturated at 2^CNT_W-1

Behaviour:
- States: IDLE, RUN, DONE, ERR (encoded in the package).
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE; result=0, valid=0, busy=0, error=0, count=0, sat=0.
  - Internal min/max/mode = 0.
  - Reset mid-run discards the run with no result.
- Legal go: go=1, finish=0, mode!=11, accepted in IDLE/DONE/ERR.
  - Next state RUN.
  - min=max=data_in; count=1; sat=0; mode latched.
  - valid=0, error=0, busy=1 from the next cycle.
- RUN, each cycle:
  - Update min=min(min,data_in), max=max(max,data_in).
  - count increments, saturating at all-ones; sat=1 once it saturates.
  - go=1, finish=0 in RUN: ignored (continuous sampling, no restart).
- Run end: finish=1, go=0 in RUN.
  - The sample on that cycle is included.
  - Next cycle: state=DONE, busy=0, valid=1, result per latched mode.
  - Latency: finish edge to valid = 1 cycle.
- Result arithmetic:
  - range = max-min, WIDTH bits, unsigned, never negative; all-equal samples give 0.
  - max/min reported as stored.
- DONE holds result/valid/count/sat until the next legal go or an error.
  - finish alone in DONE: ignored.
- Error entry (ERR next cycle, with error=1, valid=0, busy=0, result=0, count kept):
  - go=1 and finish=1 together, in any state.
  - finish=1 without go in IDLE.
  - go=1 with mode=11 in IDLE/DONE/ERR.
- ERR exits only on a legal go.
- Single-sample run (finish on the first RUN cycle): count=2; both go and finish samples included.

Decomposition:
- Package range_finder_pkg holds:
  - state typedef (IDLE/RUN/DONE/ERR).
  - mode constants MODE_RANGE=2'b00, MODE_MAX=2'b01, MODE_MIN=2'b10, MODE_RSVD=2'b11.
- One natural sub-module, range_minmax: combinational compare/update of min and max, parametrised by WIDTH.
- FSM, counter and result mux live in range_finder_multi.

Test Plan:
- Reset mid-run: go with data 5, then rst_n=0 -> all outputs 0 asynchronously; after release state IDLE, valid=0.
- Range mode, WIDTH=8: go with data 40, then 10, 200, 90; finish with data 70 -> next cycle valid=1, result=190, count=5, busy=0, error=0.
- Max/min modes on the same stream -> result=200 in mode 01, result=10 in mode 10. Mode change during RUN is ignored (latched at go).
- Errors:
  - go and finish together -> error=1, result=0, valid=0.
  - Then finish alone in IDLE after reset -> error=1.
  - mode=11 at go -> error=1.
  - A subsequent legal go clears error.
- Saturation, CNT_W=3: run of 10 samples -> count=7, sat=1, result still correct.
- Back-to-back runs: a legal go in DONE starts a new run. valid drops the cycle after go; the new result is independent of the previous run.
